store_aligner: RTL and testbench

- Write-side counterpart of the load path. Takes a store from the MEM stage: byte address, unaligned register data and the mem_op size field.
- Drives word-aligned write beats to the data memory port, with per-byte enables and data shifted into lane position.
- Splits stores that cross a word boundary into two sequential beats over a req/ack handshake.
- Holds the pipeline through st_ready until the store has been issued.

---
 rtl/store_aligner.sv | 177 +++++++++++++++++
 tb/tb_store_aligner.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_aligner.sv
// Store aligner: converts a right-justified register store into one or two
// word-aligned write beats. Each beat carries byte enables and lane-positioned
// data. A beat is issued over a req/ack handshake with the data memory port.
module store_aligner #(
  parameter int unsigned ALLOW_MISALIGNED = 1,
  parameter int unsigned ADDR_W           = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [4:0]        mem_op,
  output logic              st_done,
  output logic              st_err,
  output logic              dm_req,
  input  logic              dm_ack,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [3:0]        dm_be
);

  // Size encodings shared with the load path.
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI
  } state_t;

  state_t              state_reg;
  logic                dm_req_reg;
  logic [ADDR_W-1:0]   dm_addr_reg;
  logic [31:0]         dm_wdata_reg;
  logic [3:0]          dm_be_reg;
  logic                st_done_reg;
  logic                st_err_reg;

  // Second beat, captured at accept time so beat 1 needs no recomputation.
  logic                split_reg;
  logic [ADDR_W-1:0]   hi_addr_reg;
  logic [31:0]         hi_data_reg;
  logic [3:0]          hi_be_reg;

  logic [1:0]          off;
  logic [1:0]          size;
  logic                size_illegal;
  logic [3:0]          base_mask;
  logic [31:0]         data_masked;
  logic [7:0]          mask8;
  logic [63:0]         data64;
  logic                split;
  logic                reject;
  logic [ADDR_W-1:0]   word_addr;
  logic [ADDR_W-1:0]   next_word_addr;

  // mem_op[4:2] carries sign/extension information meaningful only to loads.
  logic                unused_op_bits;
  assign unused_op_bits = ^mem_op[4:2];

  assign off  = st_addr[1:0];
  assign size = mem_op[1:0];

  // Byte mask of the store before it is shifted into lane position.
  always_comb begin
    base_mask    = 4'b0000;
    size_illegal = 1'b0;
    case (size)
      MEM_BYTE: base_mask = 4'b0001;
      MEM_HALF: base_mask = 4'b0011;
      MEM_WORD: base_mask = 4'b1111;
      default:  size_illegal = 1'b1;
    endcase
  end

  // Zero the register bytes beyond the store size so unused lanes stay 0.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane_mask
      assign data_masked[8*gi +: 8] = st_data[8*gi +: 8] & {8{base_mask[gi]}};
    end
  endgenerate

  // Shift the mask and the data across a two-word window. The upper word
  // is non-empty only when the store runs past the end of its first word.
  assign mask8  = {4'b0000, base_mask} << off;
  assign data64 = {32'h0000_0000, data_masked} << {off, 3'b000};
  assign split  = |mask8[7:4];

  assign reject = size_illegal || (split && (ALLOW_MISALIGNED == 0));

  // The second beat address wraps naturally at the top of the address space.
  assign word_addr      = {st_addr[ADDR_W-1:2], 2'b00};
  assign next_word_addr = word_addr + ADDR_W'(4);

  assign st_ready = (state_reg == S_IDLE);
  assign dm_req   = dm_req_reg;
  assign dm_addr  = dm_addr_reg;
  assign dm_wdata = dm_wdata_reg;
  assign dm_be    = dm_be_reg;
  assign st_done  = st_done_reg;
  assign st_err   = st_err_reg;

  // Beat sequencer: IDLE -> LO (-> HI when split) -> IDLE, with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      dm_req_reg   <= 1'b0;
      dm_addr_reg  <= '0;
      dm_wdata_reg <= '0;
      dm_be_reg    <= 4'b0000;
      st_done_reg  <= 1'b0;
      st_err_reg   <= 1'b0;
      split_reg    <= 1'b0;
      hi_addr_reg  <= '0;
      hi_data_reg  <= '0;
      hi_be_reg    <= 4'b0000;
    end else begin
      st_done_reg <= 1'b0;
      st_err_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // dm_ack is ignored here since no beat is outstanding.
          if (st_valid) begin
            if (reject) begin
              st_err_reg <= 1'b1;
            end else begin
              state_reg    <= S_LO;
              dm_req_reg   <= 1'b1;
              dm_addr_reg  <= word_addr;
              dm_wdata_reg <= data64[31:0];
              dm_be_reg    <= mask8[3:0];
              split_reg    <= split;
              hi_addr_reg  <= next_word_addr;
              hi_data_reg  <= data64[63:32];
              hi_be_reg    <= mask8[7:4];
            end
          end
        end
        S_LO: begin
          if (dm_ack) begin
            if (split_reg) begin
              // Present beat 1 immediately; dm_req stays high with no bubble.
              state_reg    <= S_HI;
              dm_addr_reg  <= hi_addr_reg;
              dm_wdata_reg <= hi_data_reg;
              dm_be_reg    <= hi_be_reg;
            end else begin
              state_reg   <= S_IDLE;
              dm_req_reg  <= 1'b0;
              dm_be_reg   <= 4'b0000;
              st_done_reg <= 1'b1;
            end
          end
        end
        S_HI: begin
          if (dm_ack) begin
            state_reg   <= S_IDLE;
            dm_req_reg  <= 1'b0;
            dm_be_reg   <= 4'b0000;
            st_done_reg <= 1'b1;
          end
        end
        default: begin
          state_reg  <= S_IDLE;
          dm_req_reg <= 1'b0;
          dm_be_reg  <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_aligner.sv
// Testbench for store_aligner: directed vector table, hand-written corner
// sequences and randomized stores checked against a byte-level model.
module tb_store_aligner;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_valid0;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [4:0]  mem_op;
  logic        dm_ack;

  logic        st_ready, st_done, st_err, dm_req;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;

  logic        s_st_ready, s_st_done, s_st_err, s_dm_req;
  logic [31:0] s_dm_addr, s_dm_wdata;
  logic [3:0]  s_dm_be;

  store_aligner #(.ALLOW_MISALIGNED(1), .ADDR_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .mem_op(mem_op),
    .st_done(st_done), .st_err(st_err),
    .dm_req(dm_req), .dm_ack(dm_ack),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be)
  );

  store_aligner #(.ALLOW_MISALIGNED(0), .ADDR_W(32)) u_strict (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid0), .st_ready(s_st_ready),
    .st_addr(st_addr), .st_data(st_data), .mem_op(mem_op),
    .st_done(s_st_done), .st_err(s_st_err),
    .dm_req(s_dm_req), .dm_ack(dm_ack),
    .dm_addr(s_dm_addr), .dm_wdata(s_dm_wdata), .dm_be(s_dm_be)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] obs_addr[$], obs_data[$];
  logic [3:0]  obs_be[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic [3:0]  exp_be[$];
  int          obs_done, obs_err, obs_cycles;
  bit          unstable, busy_ready_bad;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  op;
    bit          err;
    int          nb;
    int          cycles;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [3:0]  b0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [3:0]  b1;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_stall(input int stall);
    if (stall < 0) return int'($urandom_range(0, 2));
    return stall;
  endfunction

  // Byte-level reference: walk the bytes of the store, place each at its own
  // address and group them by containing word.
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       input bit allow, output bit e_err);
    int n;
    logic [31:0] ba, w, wa, wd;
    logic [3:0]  wb;
    logic [1:0]  lane;
    bit          have;
    exp_addr.delete(); exp_data.delete(); exp_be.delete();
    e_err = 1'b0;
    wa = '0; wd = '0; wb = '0;
    if (sz == 2'd3) begin
      e_err = 1'b1;
      return;
    end
    n = 1 << sz;
    if (!allow && (int'(a[1:0]) + n > 4)) begin
      e_err = 1'b1;
      return;
    end
    have = 1'b0;
    for (int k = 0; k < n; k++) begin
      ba   = a + 32'(k);
      w    = {ba[31:2], 2'b00};
      lane = ba[1:0];
      if (have && (w != wa)) begin
        exp_addr.push_back(wa); exp_data.push_back(wd); exp_be.push_back(wb);
        have = 1'b0;
      end
      if (!have) begin
        wa = w; wd = '0; wb = '0; have = 1'b1;
      end
      wd[8*lane +: 8] = d[8*k +: 8];
      wb[lane] = 1'b1;
    end
    exp_addr.push_back(wa); exp_data.push_back(wd); exp_be.push_back(wb);
  endtask

  // Issue one store to u_dut and record every accepted beat. stall<0 picks a
  // random ack delay per beat; stall>=0 holds dm_ack low that many cycles.
  // noise keeps st_valid high with junk while the unit is busy.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [4:0] op,
                          input int stall, input bit noise);
    int          cyc, wait_left;
    bit          prev_stalled, finished;
    logic [31:0] pa, pd;
    logic [3:0]  pb;
    obs_addr.delete(); obs_data.delete(); obs_be.delete();
    obs_done = 0; obs_err = 0; obs_cycles = 0;
    unstable = 1'b0; busy_ready_bad = 1'b0;
    pa = '0; pd = '0; pb = '0;
    check("ready before request", st_ready, 1'b1);
    st_valid = 1'b1; st_addr = a; st_data = d; mem_op = op;
    dm_ack = (stall == 0);
    tick();
    st_valid = noise;
    if (noise) begin
      st_addr = ~a; st_data = ~d; mem_op = 5'b00010;
    end
    prev_stalled = 1'b0;
    finished = 1'b0;
    wait_left = pick_stall(stall);
    cyc = 0;
    while (cyc < 60) begin
      cyc++;
      if (st_done) obs_done++;
      if (st_err) obs_err++;
      if (st_done || st_err) begin
        finished = 1'b1;
        break;
      end
      if (dm_req) begin
        if (st_ready) busy_ready_bad = 1'b1;
        if (prev_stalled && (dm_addr !== pa || dm_wdata !== pd || dm_be !== pb)) unstable = 1'b1;
        if (wait_left > 0) begin
          dm_ack = 1'b0;
          wait_left--;
          prev_stalled = 1'b1;
        end else begin
          dm_ack = 1'b1;
          obs_addr.push_back(dm_addr); obs_data.push_back(dm_wdata); obs_be.push_back(dm_be);
          prev_stalled = 1'b0;
          wait_left = pick_stall(stall);
        end
        pa = dm_addr; pd = dm_wdata; pb = dm_be;
      end else begin
        dm_ack = (stall == 0);
        prev_stalled = 1'b0;
      end
      tick();
    end
    st_valid = 1'b0;
    obs_cycles = cyc;
    if (!finished) check("store timeout", 1'b0, 1'b1);
    check("idle after store", {st_ready, dm_req, dm_be}, {1'b1, 1'b0, 4'b0000});
    dm_ack = (stall == 0);
    $display("store addr=%08h data=%08h op=%05b beats=%0d done=%0d err=%0d cycles=%0d",
             a, d, op, obs_addr.size(), obs_done, obs_err, obs_cycles);
  endtask

  task automatic cmp_result(input string tag, input bit e_err);
    check({tag, " err"}, 64'(obs_err), 64'(e_err));
    check({tag, " done"}, 64'(obs_done), e_err ? 64'd0 : 64'd1);
    check({tag, " beats"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
    if (obs_addr.size() == exp_addr.size()) begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        check($sformatf("%s beat%0d addr", tag, i), obs_addr[i], exp_addr[i]);
        check($sformatf("%s beat%0d data", tag, i), obs_data[i], exp_data[i]);
        check($sformatf("%s beat%0d be", tag, i), obs_be[i], exp_be[i]);
      end
    end
    check({tag, " stable/ready"}, {unstable, busy_ready_bad}, 2'b00);
  endtask

  initial begin
    bit          e_err;
    logic [31:0] ra, rd;
    logic [4:0]  rop;

    vecs[0] = '{32'h0000_1002, 32'hFFFF_FFAB, 5'b00000, 1'b0, 1, 2,
                32'h0000_1000, 32'h00AB_0000, 4'b0100, 32'h0, 32'h0, 4'b0000};
    vecs[1] = '{32'h0000_2003, 32'h0000_BEEF, 5'b00001, 1'b0, 2, 3,
                32'h0000_2000, 32'hEF00_0000, 4'b1000, 32'h0000_2004, 32'h0000_00BE, 4'b0001};
    vecs[2] = '{32'h0000_3001, 32'h1122_3344, 5'b00010, 1'b0, 2, 3,
                32'h0000_3000, 32'h2233_4400, 4'b1110, 32'h0000_3004, 32'h0000_0011, 4'b0001};
    vecs[3] = '{32'h0000_4000, 32'hDEAD_BEEF, 5'b00010, 1'b0, 1, 2,
                32'h0000_4000, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'h0, 4'b0000};
    vecs[4] = '{32'h0000_5003, 32'h1234_5678, 5'b11100, 1'b0, 1, 2,
                32'h0000_5000, 32'h7800_0000, 4'b1000, 32'h0, 32'h0, 4'b0000};
    vecs[5] = '{32'h0000_5100, 32'h1234_5678, 5'b00011, 1'b1, 0, 1,
                32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0000_CAFE, 5'b00001, 1'b0, 2, 3,
                32'hFFFF_FFFC, 32'hFE00_0000, 4'b1000, 32'h0000_0000, 32'h0000_00CA, 4'b0001};
    vecs[7] = '{32'h0000_6002, 32'hFFFF_1234, 5'b00001, 1'b0, 1, 2,
                32'h0000_6000, 32'h1234_0000, 4'b1100, 32'h0, 32'h0, 4'b0000};

    rst_n = 1'b0; st_valid = 1'b0; st_valid0 = 1'b0;
    st_addr = '0; st_data = '0; mem_op = '0; dm_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset dm_req", dm_req, 1'b0);
    check("reset dm_addr", dm_addr, 32'h0);
    check("reset dm_wdata", dm_wdata, 32'h0);
    check("reset dm_be", dm_be, 4'b0000);
    check("reset done/err", {st_done, st_err}, 2'b00);
    check("reset st_ready", st_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Directed vectors, dm_ack tied high.
    for (int i = 0; i < 8; i++) begin
      do_store(vecs[i].addr, vecs[i].data, vecs[i].op, 0, 1'b0);
      exp_addr.delete(); exp_data.delete(); exp_be.delete();
      if (vecs[i].nb >= 1) begin
        exp_addr.push_back(vecs[i].a0); exp_data.push_back(vecs[i].d0); exp_be.push_back(vecs[i].b0);
      end
      if (vecs[i].nb == 2) begin
        exp_addr.push_back(vecs[i].a1); exp_data.push_back(vecs[i].d1); exp_be.push_back(vecs[i].b1);
      end
      cmp_result($sformatf("vec%0d", i), vecs[i].err);
      check($sformatf("vec%0d cycles", i), 64'(obs_cycles), 64'(vecs[i].cycles));
      tick();
      check($sformatf("vec%0d quiet after", i), {st_done, st_err, dm_req}, 3'b000);
    end

    // Aligned word with a 3-cycle ack stall while junk requests are offered.
    do_store(32'h0000_4000, 32'hDEAD_BEEF, 5'b00010, 3, 1'b1);
    exp_addr.delete(); exp_data.delete(); exp_be.delete();
    exp_addr.push_back(32'h0000_4000); exp_data.push_back(32'hDEAD_BEEF); exp_be.push_back(4'b1111);
    cmp_result("stall", 1'b0);
    check("stall cycles", 64'(obs_cycles), 64'd5);
    tick();
    check("stall junk not accepted", {dm_req, st_done}, 2'b00);

    // Async reset right after the beat-0 ack of a split store.
    dm_ack = 1'b1;
    st_valid = 1'b1; st_addr = 32'h0000_2003; st_data = 32'h0000_BEEF; mem_op = 5'b00001;
    tick();
    st_valid = 1'b0;
    check("rst seq beat0", {dm_req, dm_be}, {1'b1, 4'b1000});
    tick();
    check("rst seq beat1 shown", {dm_req, dm_be}, {1'b1, 4'b0001});
    rst_n = 1'b0;
    #1;
    check("rst seq req dropped", {dm_req, dm_be}, {1'b0, 4'b0000});
    check("rst seq ready in reset", st_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst seq quiet %0d", i), {dm_req, st_done, st_ready}, 3'b001);
    end

    // Illegal size, then back-to-back byte stores.
    do_store(32'h0000_7000, 32'h0000_00FF, 5'b00011, 0, 1'b0);
    exp_addr.delete(); exp_data.delete(); exp_be.delete();
    cmp_result("illegal", 1'b1);
    tick();
    check("illegal err one pulse", {st_err, dm_req}, 2'b00);
    dm_ack = 1'b1;
    st_valid = 1'b1; st_addr = 32'h0000_0010; st_data = 32'h0000_0055; mem_op = 5'b00000;
    tick();
    check("b2b A beat", {dm_req, dm_addr, dm_wdata, dm_be}, {1'b1, 32'h0000_0010, 32'h0000_0055, 4'b0001});
    check("b2b A busy", st_ready, 1'b0);
    st_addr = 32'h0000_0021; st_data = 32'h0000_0066;
    tick();
    check("b2b A done", {st_done, st_ready}, 2'b11);
    tick();
    st_valid = 1'b0;
    check("b2b B beat", {dm_req, dm_addr, dm_wdata, dm_be}, {1'b1, 32'h0000_0020, 32'h0000_6600, 4'b0010});
    check("b2b B no done yet", st_done, 1'b0);
    tick();
    check("b2b B done", st_done, 1'b1);
    tick();
    check("b2b idle", {st_done, dm_req}, 2'b00);

    // Strict instance: boundary-crossing store is rejected.
    st_valid0 = 1'b1; st_addr = 32'h0000_3001; st_data = 32'h1122_3344; mem_op = 5'b00010;
    tick();
    st_valid0 = 1'b0;
    check("strict err", {s_st_err, s_dm_req, s_st_ready}, 3'b101);
    tick();
    check("strict after err", {s_st_err, s_dm_req, s_st_ready}, 3'b001);
    st_valid0 = 1'b1; st_addr = 32'h0000_3001; st_data = 32'h0000_A5A5; mem_op = 5'b00001;
    tick();
    st_valid0 = 1'b0;
    check("strict inword half", {s_dm_req, s_st_err, s_dm_addr, s_dm_wdata, s_dm_be},
          {1'b1, 1'b0, 32'h0000_3000, 32'h00A5_A500, 4'b0110});
    tick();
    check("strict done", {s_st_done, s_dm_req}, 2'b10);

    // Randomized stores against the byte-level model.
    for (int t = 0; t < 150; t++) begin
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra[31:2] = 30'h3FFF_FFFF;
      rd = $urandom;
      rop = 5'($urandom);
      rop[1:0] = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_store(ra, rd, rop, -1, 1'($urandom_range(0, 1)));
      model(ra, rd, rop[1:0], 1'b1, e_err);
      cmp_result($sformatf("rand%0d", t), e_err);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
